// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - requester-side bus of the shared multiplier arbiter
interface mul_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [2*WIDTH-1:0]    result;
  logic                  err;

  modport master (
    output req, req_a, req_b,
    input  gnt, done, result, err
  );

  modport slave (
    input  req, req_a, req_b,
    output gnt, done, result, err
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one shift-add multiplier among NREQ clients
module mul_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  mul_share_arbiter_if.slave bus,
  output logic               mul_clr,
  output logic               mul_run,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_ready,
  input  logic [2*WIDTH-1:0] mul_product
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {IDLE, CLR, RUN, WAIT, DONE} state_t;

  state_t             state, state_n;
  logic [PW-1:0]      ptr, ptr_n;
  logic [PW-1:0]      gidx, gidx_n;
  logic [PW-1:0]      pick;
  logic               pick_vld;
  logic [WW-1:0]      wdog, wdog_n;
  logic [NREQ-1:0]    gnt_n;
  logic [2*WIDTH-1:0] result_n;
  logic               err_n;
  logic [WIDTH-1:0]   a_n, b_n, a_sel, b_sel;

  // Scan downward so the lowest rotation offset from ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (bus.req[idx[PW-1:0]]) begin
        pick     = idx[PW-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == i[PW-1:0]) begin
        a_sel = bus.req_a[i*WIDTH +: WIDTH];
        b_sel = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    gidx_n   = gidx;
    wdog_n   = wdog;
    gnt_n    = bus.gnt;
    result_n = bus.result;
    err_n    = bus.err;
    a_n      = mul_a;
    b_n      = mul_b;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          gidx_n  = pick;
          gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          a_n     = a_sel;
          b_n     = b_sel;
          state_n = CLR;
        end
      end
      CLR: state_n = RUN;
      RUN: begin
        wdog_n  = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // A ready arriving on the final watchdog cycle still counts as success.
        if (mul_ready) begin
          result_n = mul_product;
          err_n    = 1'b0;
          state_n  = DONE;
        end else if (wdog == WW'(TIMEOUT - 1)) begin
          result_n = '0;
          err_n    = 1'b1;
          state_n  = DONE;
        end else begin
          wdog_n = wdog + WW'(1);
        end
      end
      DONE: begin
        ptr_n   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
        gnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      gidx       <= '0;
      wdog       <= '0;
      bus.gnt    <= '0;
      bus.done   <= '0;
      bus.result <= '0;
      bus.err    <= 1'b0;
      mul_clr    <= 1'b0;
      mul_run    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      gidx       <= gidx_n;
      wdog       <= wdog_n;
      bus.gnt    <= gnt_n;
      bus.done   <= (state_n == DONE) ? gnt_n : '0;
      bus.result <= result_n;
      bus.err    <= err_n;
      mul_clr    <= (state_n == CLR);
      mul_run    <= (state_n == RUN);
      mul_a      <= a_n;
      mul_b      <= b_n;
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - scoreboard bench with a behavioural multiplier and arbitration model
module tb_mul_share_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 64;
  localparam int NEVER   = 1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  logic               mul_clr, mul_run, mul_ready;
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_product;

  mul_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .mul_clr    (mul_clr),
    .mul_run    (mul_run),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_ready  (mul_ready),
    .mul_product(mul_product)
  );

  typedef struct {
    logic [NREQ-1:0]    onehot;
    logic [2*WIDTH-1:0] res;
    logic               err;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  exp_t exp_q[$];
  int lat_q[$];
  logic [WIDTH-1:0] op_a[NREQ];
  logic [WIDTH-1:0] op_b[NREQ];
  int mptr;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick_w();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return NEVER;
    if (r == 1) return TIMEOUT;
    if (r == 2) return TIMEOUT + 1;
    return $urandom_range(1, 40);
  endfunction

  // Multiplier: ready becomes visible in the w-th cycle after the run pulse, product only then.
  initial begin
    int cnt, w;
    bit active;
    logic [63:0] p;
    mul_ready = 1'b0;
    mul_product = '0;
    active = 1'b0;
    cnt = 0;
    w = 0;
    p = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mul_run) begin
        mul_ready = 1'b0;
        active = 1'b1;
        cnt = 0;
        w = (lat_q.size() > 0) ? lat_q.pop_front() : NEVER;
        p = {32'b0, mul_a} * {32'b0, mul_b};
        mul_product = {$urandom, $urandom};
      end else if (active) begin
        cnt++;
        if (cnt >= w) begin
          mul_ready = 1'b1;
          mul_product = p;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("gnt_onehot", $onehot0(bus.gnt), bus.gnt, 0);
        if (bus.done != '0) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_done", 1'b0, bus.done, 0);
          end else begin
            e = exp_q.pop_front();
            check("done_who", bus.done == e.onehot, bus.done, e.onehot);
            check("done_eq_gnt", bus.done == bus.gnt, bus.done, bus.gnt);
            check("result", bus.result == e.res, bus.result, e.res);
            check("err", bus.err == e.err, bus.err, e.err);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, bus.gnt == '0, bus.gnt, 0);
    check({tag, "_done"}, bus.done == '0, bus.done, 0);
    check({tag, "_result"}, bus.result == '0, bus.result, 0);
    check({tag, "_err"}, bus.err == 1'b0, bus.err, 0);
    check({tag, "_mul_clr"}, mul_clr == 1'b0, mul_clr, 0);
    check({tag, "_mul_run"}, mul_run == 1'b0, mul_run, 0);
    check({tag, "_mul_a"}, mul_a == '0, mul_a, 0);
    check({tag, "_mul_b"}, mul_b == '0, mul_b, 0);
  endtask

  task automatic do_round(input logic [NREQ-1:0] pat, input logic [NREQ-1:0] drop,
                          input int fixed_w, input bit keep_ops);
    logic [NREQ-1:0] left, first_oh;
    int idx, w, remaining, runs, cyc, budget;
    bit got;
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (pat[i]) begin
        if (!keep_ops) begin
          op_a[i] = $urandom;
          op_b[i] = $urandom;
        end
        bus.req_a[i*WIDTH +: WIDTH] = op_a[i];
        bus.req_b[i*WIDTH +: WIDTH] = op_b[i];
      end
    end
    left = pat;
    first_oh = '0;
    idx = 0;
    while (left != '0) begin
      got = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        if (!got && left[(mptr + k) % NREQ]) begin
          idx = (mptr + k) % NREQ;
          got = 1'b1;
        end
      end
      w = (fixed_w > 0) ? fixed_w : pick_w();
      lat_q.push_back(w);
      e.onehot = '0;
      e.onehot[idx] = 1'b1;
      if (first_oh == '0) first_oh = e.onehot;
      e.err = (w > TIMEOUT);
      e.res = e.err ? 64'd0 : {32'b0, op_a[idx]} * {32'b0, op_b[idx]};
      exp_q.push_back(e);
      left[idx] = 1'b0;
      mptr = (idx + 1) % NREQ;
    end
    bus.req = pat;
    remaining = $countones(pat);
    budget = remaining * (TIMEOUT + 12) + 10;
    runs = 0;
    cyc = 0;
    while (remaining > 0 && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check("gnt_latency", bus.gnt == first_oh, bus.gnt, first_oh);
        check("clr_latency", mul_clr == 1'b1, mul_clr, 1);
      end
      if (cyc == 2) check("run_latency", mul_run == 1'b1, mul_run, 1);
      if (mul_run) runs++;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.done[i]) begin
          bus.req[i] = 1'b0;
          remaining--;
        end else if (bus.gnt[i]) begin
          bus.req_a[i*WIDTH +: WIDTH] = $urandom;
          bus.req_b[i*WIDTH +: WIDTH] = $urandom;
          if (drop[i]) bus.req[i] = 1'b0;
        end
      end
    end
    check("round_complete", remaining == 0, remaining, 0);
    check("run_pulses", runs == $countones(pat), runs, $countones(pat));
    if (remaining != 0) begin
      bus.req = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      lat_q.delete();
      mptr = 0;
    end
  endtask

  task automatic reset_mid_wait();
    int cyc, d0;
    bit seen_run;
    @(posedge clk);
    #1;
    bus.req_a[WIDTH +: WIDTH] = 32'd7;
    bus.req_b[WIDTH +: WIDTH] = 32'd9;
    lat_q.push_back(20);
    bus.req = 4'b0010;
    cyc = 0;
    seen_run = 1'b0;
    while (!seen_run && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
      seen_run = mul_run;
    end
    check("rst_reach_run", seen_run, seen_run, 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req = '0;
    check_all_zero("midrst");
    mptr = 0;
    lat_q.delete();
    d0 = done_seen;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_rst", done_seen == d0, done_seen - d0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    mptr = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    op_a[0] = 32'd3;
    op_b[0] = 32'd5;
    do_round(4'b0001, 4'b0000, 33, 1'b1);

    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = 32'h100 + i;
      op_b[i] = 32'h10 + i;
    end
    op_a[2] = 32'hFFFF_FFFF;
    op_b[2] = 32'd2;
    do_round(4'b1111, 4'b0000, 10, 1'b1);
    do_round(4'b0001, 4'b0000, 10, 1'b0);

    do_round(4'b0001, 4'b0000, NEVER, 1'b0);
    do_round(4'b0001, 4'b0000, 7, 1'b0);

    reset_mid_wait();

    do_round(4'b0100, 4'b0000, 5, 1'b0);
    do_round(4'b0101, 4'b0000, 5, 1'b0);
    do_round(4'b1111, 4'b0000, 5, 1'b0);

    do_round(4'b0010, 4'b0010, TIMEOUT, 1'b0);
    do_round(4'b0001, 4'b0000, TIMEOUT + 1, 1'b0);

    repeat (25) begin
      do_round(4'($urandom_range(1, 15)), 4'($urandom), 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("leftover_expect", exp_q.size() == 0, exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
